// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the pc, drives the instruction memory address
// and registers the returned word into the IF/ID pipeline register.
// Handles stall, redirect/flush, misaligned and out-of-range faults, EBREAK halt.
//
// state | meaning
// BOOT  | one bubble cycle after reset, pc held
// RUN   | fetching sequentially, honours redirect and stall
// HALT  | EBREAK issued; pc frozen until reset
// FAULT | misaligned redirect or out-of-range fetch; frozen until reset
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  // Range check is done in 33 bits so pc+3 cannot wrap and look in range.
  localparam logic [32:0] IMEM_LIMIT  = 33'(IMEM_BYTES);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        id_valid_nx;
  logic [31:0] id_inst_nx, id_pc_nx, id_pc4_nx;
  logic        halted_nx, fault_nx;
  logic [31:0] fault_pc_nx;
  logic [31:0] pc_plus4;
  logic [32:0] pc_last_byte;

  assign imem_addr    = pc;
  assign pc_plus4     = pc + 32'd4;
  assign pc_last_byte = {1'b0, pc} + 33'd3;

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    id_valid_nx = id_valid;
    id_inst_nx  = id_inst;
    id_pc_nx    = id_pc;
    id_pc4_nx   = id_pc4;
    halted_nx   = halted;
    fault_nx    = fault;
    fault_pc_nx = fault_pc;
    case (state)
      BOOT: begin
        id_valid_nx = 1'b0;
        state_nx    = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          id_valid_nx = 1'b0;
          id_inst_nx  = NOP_INST;
          if (redirect_target[1:0] != 2'b00) begin
            state_nx    = FAULT;
            fault_nx    = 1'b1;
            fault_pc_nx = redirect_target;
          end else begin
            pc_nx = redirect_target;
          end
        end else if (stall) begin
          // hold everything
        end else if (pc_last_byte >= IMEM_LIMIT) begin
          state_nx    = FAULT;
          fault_nx    = 1'b1;
          fault_pc_nx = pc;
          id_valid_nx = 1'b0;
          id_inst_nx  = NOP_INST;
        end else begin
          id_inst_nx  = imem_inst;
          id_pc_nx    = pc;
          id_pc4_nx   = pc_plus4;
          id_valid_nx = 1'b1;
          if (imem_inst == EBREAK_INST) begin
            // EBREAK still issues to decode, but the pc stops on it.
            state_nx  = HALT;
            halted_nx = 1'b1;
          end else begin
            pc_nx = pc_plus4;
          end
        end
      end
      HALT: begin
        if (!stall) begin
          id_valid_nx = 1'b0;
          id_inst_nx  = NOP_INST;
        end
      end
      FAULT: begin
        id_valid_nx = 1'b0;
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
      id_pc    <= 32'd0;
      id_pc4   <= 32'd0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= 32'd0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      id_valid <= id_valid_nx;
      id_inst  <= id_inst_nx;
      id_pc    <= id_pc_nx;
      id_pc4   <= id_pc4_nx;
      halted   <= halted_nx;
      fault    <= fault_nx;
      fault_pc <= fault_pc_nx;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small 20-byte instruction memory.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        halted;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [0:7];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_inst = (imem_addr < 32'd32) ? mem[imem_addr[4:2]] : 32'd0;

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(20),
    .NOP_INST  (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_id_inst got %08h want %08h", id_inst, NOP); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_pc got %08h want 0", imem_addr); end
    checks++; if ({halted, fault, fault_pc, id_pc, id_pc4} !== 98'd0) begin errors++; $display("FAIL reset_flags got h=%0b f=%0b fpc=%08h idpc=%08h pc4=%08h want all 0", halted, fault, fault_pc, id_pc, id_pc4); end
    // BOOT bubble
    step();
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL boot_bubble got v=%0b pc=%08h want v=0 pc=0", id_valid, imem_addr); end
  endtask

  task automatic test_sequential();
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_inst !== 32'h00A9_8933 || id_pc4 !== 32'd4) begin errors++; $display("FAIL fetch0 got v=%0b pc=%08h inst=%08h pc4=%08h", id_valid, id_pc, id_inst, id_pc4); end
    step();
    checks++; if (id_pc !== 32'd4 || id_inst !== 32'hFCE0_8793 || id_pc4 !== 32'd8 || imem_addr !== 32'd8) begin errors++; $display("FAIL fetch4 got pc=%08h inst=%08h pc4=%08h addr=%08h", id_pc, id_inst, id_pc4, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'd8 || id_pc !== 32'd4 || id_inst !== 32'hFCE0_8793 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got addr=%08h idpc=%08h inst=%08h v=%0b", i, imem_addr, id_pc, id_inst, id_valid); end
    end
    stall = 1'b0;
    step();
    checks++; if (id_pc !== 32'd8 || id_inst !== 32'h00E1_2423 || id_pc4 !== 32'd12 || imem_addr !== 32'd12) begin errors++; $display("FAIL stall_release got idpc=%08h inst=%08h pc4=%08h addr=%08h", id_pc, id_inst, id_pc4, imem_addr); end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd0;
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== NOP || imem_addr !== 32'd0) begin errors++; $display("FAIL redirect_flush got v=%0b inst=%08h addr=%08h want 0/%08h/0", id_valid, id_inst, imem_addr, NOP); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_inst !== 32'h00A9_8933) begin errors++; $display("FAIL redirect_refetch got v=%0b idpc=%08h inst=%08h", id_valid, id_pc, id_inst); end
  endtask

  task automatic test_ebreak();
    // pc is 4; fetch 4, 8, 12 then EBREAK at 16
    step(); step(); step();
    checks++; if (id_pc !== 32'd12 || id_inst !== 32'h00B5_0533) begin errors++; $display("FAIL pre_ebreak got idpc=%08h inst=%08h", id_pc, id_inst); end
    step();
    checks++; if (id_inst !== EBREAK || id_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 32'd16 || id_pc !== 32'd16) begin errors++; $display("FAIL ebreak_issue got inst=%08h v=%0b h=%0b addr=%08h idpc=%08h", id_inst, id_valid, halted, imem_addr, id_pc); end
    redirect_valid = 1'b1;
    redirect_target = 32'd0;
    step();
    checks++; if (id_valid !== 1'b0 || id_inst !== NOP || imem_addr !== 32'd16) begin errors++; $display("FAIL halt_bubble got v=%0b inst=%08h addr=%08h", id_valid, id_inst, imem_addr); end
    step();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b1 || fault !== 1'b0 || imem_addr !== 32'd16) begin errors++; $display("FAIL halt_sticky got h=%0b f=%0b addr=%08h", halted, fault, imem_addr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared got %0b want 0", halted); end
    step();         // BOOT
    step();         // fetch 0, pc -> 4
    redirect_valid = 1'b1;
    redirect_target = 32'd6;
    step();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'd6 || imem_addr !== 32'd4 || id_valid !== 1'b0) begin errors++; $display("FAIL misalign got f=%0b fpc=%08h addr=%08h v=%0b", fault, fault_pc, imem_addr, id_valid); end
    redirect_target = 32'd8;
    step();
    step();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || fault_pc !== 32'd6 || imem_addr !== 32'd4 || id_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL fault_sticky got f=%0b fpc=%08h addr=%08h v=%0b h=%0b", fault, fault_pc, imem_addr, id_valid, halted); end
    do_reset();
    checks++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin errors++; $display("FAIL fault_cleared got f=%0b fpc=%08h", fault, fault_pc); end
  endtask

  task automatic test_range_fault();
    mem[4] = 32'h0000_0533;
    step();         // BOOT
    for (int i = 0; i < 5; i++) step();
    checks++; if (id_pc !== 32'd16 || id_inst !== 32'h0000_0533 || imem_addr !== 32'd20 || fault !== 1'b0) begin errors++; $display("FAIL last_fetch got idpc=%08h inst=%08h addr=%08h f=%0b", id_pc, id_inst, imem_addr, fault); end
    step();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'd20 || id_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'd20) begin errors++; $display("FAIL range_fault got f=%0b fpc=%08h v=%0b h=%0b addr=%08h", fault, fault_pc, id_valid, halted, imem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (imem_addr !== 32'd0 || fault !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL midrun_reset got addr=%08h f=%0b v=%0b", imem_addr, fault, id_valid); end
    step();
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL midrun_boot got v=%0b addr=%08h", id_valid, imem_addr); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_inst !== 32'h00A9_8933) begin errors++; $display("FAIL midrun_refetch got v=%0b idpc=%08h inst=%08h", id_valid, id_pc, id_inst); end
  endtask

  initial begin
    mem[0] = 32'h00A9_8933;
    mem[1] = 32'hFCE0_8793;
    mem[2] = 32'h00E1_2423;
    mem[3] = 32'h00B5_0533;
    mem[4] = EBREAK;
    mem[5] = 32'd0;
    mem[6] = 32'd0;
    mem[7] = 32'd0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_ebreak();
    test_misaligned();
    test_range_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
